// File: rtl/bp_nonsynth_dma_mux.sv
// N:1 DMA concentrator in front of a single-port nonsynth DRAM model: round-robin packet grant, in-order source tracking.
// Define BP_DMA_MUX_ASSERT_EN to enable simulation-only protocol checks; the datapath is identical either way.
module bp_nonsynth_dma_mux #(
  parameter int num_dma_p               = 2,
  parameter int daddr_width_p           = 32,
  parameter int l2_fill_width_p         = 64,
  parameter int l2_block_size_in_fill_p = 8,
  parameter int rd_fifo_els_p           = 4,
  parameter int wr_fifo_els_p           = 2,
  localparam int dma_pkt_width_lp       = daddr_width_p + 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_dma_p*dma_pkt_width_lp-1:0]  dma_pkt_i,
  input  logic [num_dma_p-1:0]                   dma_pkt_v_i,
  output logic [num_dma_p-1:0]                   dma_pkt_yumi_o,
  output logic [num_dma_p*l2_fill_width_p-1:0]   dma_data_o,
  output logic [num_dma_p-1:0]                   dma_data_v_o,
  input  logic [num_dma_p-1:0]                   dma_data_ready_and_i,
  input  logic [num_dma_p*l2_fill_width_p-1:0]   dma_data_i,
  input  logic [num_dma_p-1:0]                   dma_data_v_i,
  output logic [num_dma_p-1:0]                   dma_data_yumi_o,
  output logic [dma_pkt_width_lp-1:0]            mem_dma_pkt_o,
  output logic                                   mem_dma_pkt_v_o,
  input  logic                                   mem_dma_pkt_yumi_i,
  input  logic [l2_fill_width_p-1:0]             mem_dma_data_i,
  input  logic                                   mem_dma_data_v_i,
  output logic                                   mem_dma_data_ready_and_o,
  output logic [l2_fill_width_p-1:0]             mem_dma_data_o,
  output logic                                   mem_dma_data_v_o,
  input  logic                                   mem_dma_data_yumi_i
);

  localparam int id_w_lp  = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
  localparam int cnt_w_lp = (l2_block_size_in_fill_p > 1) ? $clog2(l2_block_size_in_fill_p) : 1;
  localparam int rd_aw_lp = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int wr_aw_lp = (wr_fifo_els_p > 1) ? $clog2(wr_fifo_els_p) : 1;
  localparam int rd_cw_lp = $clog2(rd_fifo_els_p + 1);
  localparam int wr_cw_lp = $clog2(wr_fifo_els_p + 1);

  logic [id_w_lp-1:0]   rr_ptr, grant_id;
  logic [num_dma_p-1:0] eligible;
  logic                 pkt_hs, win_wnr;

  logic [id_w_lp-1:0]   rd_mem [rd_fifo_els_p];
  logic [rd_aw_lp-1:0]  rd_wptr, rd_rptr;
  logic [rd_cw_lp-1:0]  rd_count;
  logic                 rd_full, rd_empty, rd_push, rd_pop;

  logic [id_w_lp-1:0]   wr_mem [wr_fifo_els_p];
  logic [wr_aw_lp-1:0]  wr_wptr, wr_rptr;
  logic [wr_cw_lp-1:0]  wr_count;
  logic                 wr_full, wr_empty, wr_push, wr_pop;

  logic [cnt_w_lp-1:0]  rd_cnt, wr_cnt;
  logic                 rd_last, wr_last, rd_hs, wr_hs;
  logic [id_w_lp-1:0]   rd_dst, wr_src;

  assign rd_full  = (rd_count == rd_cw_lp'(rd_fifo_els_p));
  assign rd_empty = (rd_count == '0);
  assign wr_full  = (wr_count == wr_cw_lp'(wr_fifo_els_p));
  assign wr_empty = (wr_count == '0);

  // A port only competes if the FIFO its packet would land in has room.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_dma_p; i++)
      eligible[i] = dma_pkt_v_i[i]
                  & (dma_pkt_i[i*dma_pkt_width_lp+dma_pkt_width_lp-1] ? !wr_full : !rd_full);
  end

  always_comb begin
    int  idx;
    logic found;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < num_dma_p; k++) begin
      idx = (int'(rr_ptr) + k) % num_dma_p;
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        grant_id = id_w_lp'(idx);
      end
    end
  end

  assign mem_dma_pkt_o   = dma_pkt_i[grant_id*dma_pkt_width_lp +: dma_pkt_width_lp];
  assign mem_dma_pkt_v_o = (|eligible) & !reset_i;
  assign win_wnr         = mem_dma_pkt_o[dma_pkt_width_lp-1];
  assign pkt_hs          = mem_dma_pkt_v_o & mem_dma_pkt_yumi_i;

  always_comb begin
    dma_pkt_yumi_o = '0;
    for (int i = 0; i < num_dma_p; i++)
      dma_pkt_yumi_o[i] = pkt_hs & (grant_id == id_w_lp'(i));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_ptr <= '0;
    else if (pkt_hs)
      rr_ptr <= (grant_id == id_w_lp'(num_dma_p-1)) ? '0 : grant_id + 1'b1;
  end

  assign rd_push = pkt_hs & !win_wnr & !rd_full;
  assign wr_push = pkt_hs &  win_wnr & !wr_full;

  // Write path: head of the write FIFO owns the DRAM write-data channel.
  assign wr_src           = wr_mem[wr_rptr];
  assign mem_dma_data_o   = dma_data_i[wr_src*l2_fill_width_p +: l2_fill_width_p];
  assign mem_dma_data_v_o = !wr_empty & dma_data_v_i[wr_src];
  assign wr_hs            = mem_dma_data_v_o & mem_dma_data_yumi_i;
  assign wr_last          = (wr_cnt == cnt_w_lp'(l2_block_size_in_fill_p-1));
  assign wr_pop           = wr_hs & wr_last;

  always_comb begin
    dma_data_yumi_o = '0;
    for (int i = 0; i < num_dma_p; i++)
      dma_data_yumi_o[i] = wr_hs & (wr_src == id_w_lp'(i));
  end

  // Read path: data is broadcast, only the head-of-FIFO requester sees valid.
  assign rd_dst                   = rd_mem[rd_rptr];
  assign dma_data_o               = {num_dma_p{mem_dma_data_i}};
  assign mem_dma_data_ready_and_o = !rd_empty & dma_data_ready_and_i[rd_dst];
  assign rd_hs                    = mem_dma_data_v_i & mem_dma_data_ready_and_o;
  assign rd_last                  = (rd_cnt == cnt_w_lp'(l2_block_size_in_fill_p-1));
  assign rd_pop                   = rd_hs & rd_last;

  always_comb begin
    dma_data_v_o = '0;
    for (int i = 0; i < num_dma_p; i++)
      dma_data_v_o[i] = mem_dma_data_v_i & !rd_empty & (rd_dst == id_w_lp'(i));
  end

  always_ff @(posedge clk_i) begin
    if (rd_push) rd_mem[rd_wptr] <= grant_id;
    if (wr_push) wr_mem[wr_wptr] <= grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_count <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (rd_push) rd_wptr <= (rd_wptr == rd_aw_lp'(rd_fifo_els_p-1)) ? '0 : rd_wptr + 1'b1;
      if (rd_pop)  rd_rptr <= (rd_rptr == rd_aw_lp'(rd_fifo_els_p-1)) ? '0 : rd_rptr + 1'b1;
      if (wr_push) wr_wptr <= (wr_wptr == wr_aw_lp'(wr_fifo_els_p-1)) ? '0 : wr_wptr + 1'b1;
      if (wr_pop)  wr_rptr <= (wr_rptr == wr_aw_lp'(wr_fifo_els_p-1)) ? '0 : wr_rptr + 1'b1;
      case ({rd_push, rd_pop})
        2'b10:   rd_count <= rd_count + 1'b1;
        2'b01:   rd_count <= rd_count - 1'b1;
        default: rd_count <= rd_count;
      endcase
      case ({wr_push, wr_pop})
        2'b10:   wr_count <= wr_count + 1'b1;
        2'b01:   wr_count <= wr_count - 1'b1;
        default: wr_count <= wr_count;
      endcase
      if (rd_hs) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      if (wr_hs) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
    end
  end

`ifdef BP_DMA_MUX_ASSERT_EN
  logic [num_dma_p*dma_pkt_width_lp-1:0] pkt_q;
  logic [num_dma_p-1:0]                  pend_q;

  always @(posedge clk_i) begin
    if (reset_i) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < num_dma_p; i++) begin
        if (pend_q[i] && (!dma_pkt_v_i[i]
            || dma_pkt_i[i*dma_pkt_width_lp +: dma_pkt_width_lp] != pkt_q[i*dma_pkt_width_lp +: dma_pkt_width_lp]))
          $error("dma_mux: port %0d dropped or changed packet before yumi", i);
        if (!wr_empty && wr_cnt != '0 && dma_data_v_i[i] && wr_src != id_w_lp'(i))
          $error("dma_mux: write beat from port %0d while port %0d mid-burst", i, wr_src);
      end
      if (mem_dma_data_v_i && rd_empty)
        $error("dma_mux: read beat returned with no outstanding read");
      if (mem_dma_data_yumi_i && wr_empty)
        $error("dma_mux: write beat consumed with no pending write");
      pend_q <= dma_pkt_v_i & ~dma_pkt_yumi_o;
      pkt_q  <= dma_pkt_i;
    end
  end

  final begin
    if (!rd_empty || !wr_empty)
      $error("dma_mux: transactions outstanding at end of simulation (rd=%0d wr=%0d)", rd_count, wr_count);
  end
`endif

endmodule

// File: tb/tb_bp_nonsynth_dma_mux.sv
// Directed bench for bp_nonsynth_dma_mux (N=2, 8 fill beats per block) with hand-computed expectations.
module tb_bp_nonsynth_dma_mux;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int W = AW + 1;
  localparam int F = 64;
  localparam int B = 8;

  logic             clk_i, reset_i;
  logic [N*W-1:0]   dma_pkt_i;
  logic [N-1:0]     dma_pkt_v_i, dma_pkt_yumi_o;
  logic [N*F-1:0]   dma_data_o;
  logic [N-1:0]     dma_data_v_o, dma_data_ready_and_i;
  logic [N*F-1:0]   dma_data_i;
  logic [N-1:0]     dma_data_v_i, dma_data_yumi_o;
  logic [W-1:0]     mem_dma_pkt_o;
  logic             mem_dma_pkt_v_o, mem_dma_pkt_yumi_i;
  logic [F-1:0]     mem_dma_data_i;
  logic             mem_dma_data_v_i, mem_dma_data_ready_and_o;
  logic [F-1:0]     mem_dma_data_o;
  logic             mem_dma_data_v_o, mem_dma_data_yumi_i;

  int checks = 0;
  int failures = 0;

  bp_nonsynth_dma_mux #(
    .num_dma_p(N), .daddr_width_p(AW), .l2_fill_width_p(F),
    .l2_block_size_in_fill_p(B), .rd_fifo_els_p(4), .wr_fifo_els_p(2)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_dma_pkt_o(mem_dma_pkt_o), .mem_dma_pkt_v_o(mem_dma_pkt_v_o), .mem_dma_pkt_yumi_i(mem_dma_pkt_yumi_i),
    .mem_dma_data_i(mem_dma_data_i), .mem_dma_data_v_i(mem_dma_data_v_i),
    .mem_dma_data_ready_and_o(mem_dma_data_ready_and_o),
    .mem_dma_data_o(mem_dma_data_o), .mem_dma_data_v_o(mem_dma_data_v_o),
    .mem_dma_data_yumi_i(mem_dma_data_yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [W-1:0] mk_pkt(input logic wnr, input logic [AW-1:0] addr);
    return {wnr, addr};
  endfunction

  initial begin
    int acc;
    logic stall;
    logic [W-1:0] p;

    reset_i = 1'b1;
    dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_ready_and_i = '0;
    dma_data_i = '0; dma_data_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
    mem_dma_data_i = '0; mem_dma_data_v_i = 1'b0; mem_dma_data_yumi_i = 1'b0;
    repeat (2) tick();

    // reset: outputs quiet even with requests present
    dma_pkt_v_i = 2'b11; mem_dma_pkt_yumi_i = 1'b1;
    #3;
    check_val("rst_pkt_v", mem_dma_pkt_v_o, 1'b0);
    check_val("rst_pkt_yumi", dma_pkt_yumi_o, 2'b00);
    check_val("rst_data_v", dma_data_v_o, 2'b00);
    check_val("rst_mem_ready", mem_dma_data_ready_and_o, 1'b0);
    check_val("rst_mem_wv", mem_dma_data_v_o, 1'b0);
    check_val("rst_data_yumi", dma_data_yumi_o, 2'b00);
    tick();
    dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0; reset_i = 1'b0;
    tick();

    // two reads in the same cycle, then two bursts returned in order
    dma_pkt_i[0*W +: W] = mk_pkt(1'b0, 32'h8000_0000);
    dma_pkt_i[1*W +: W] = mk_pkt(1'b0, 32'h8000_0040);
    dma_pkt_v_i = 2'b11; mem_dma_pkt_yumi_i = 1'b1;
    #3;
    check_val("t1_yumi0", dma_pkt_yumi_o, 2'b01);
    check_val("t1_pkt0", mem_dma_pkt_o, mk_pkt(1'b0, 32'h8000_0000));
    tick();
    dma_pkt_v_i = 2'b10;
    #3;
    check_val("t1_yumi1", dma_pkt_yumi_o, 2'b10);
    check_val("t1_pkt1", mem_dma_pkt_o, mk_pkt(1'b0, 32'h8000_0040));
    tick();
    dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
    dma_data_ready_and_i = 2'b11;
    for (int k = 0; k < 2*B; k++) begin
      mem_dma_data_v_i = 1'b1; mem_dma_data_i = 64'h1000 + 64'(k);
      #3;
      check_val("t1_rd_v", dma_data_v_o, (k < B) ? 2'b01 : 2'b10);
      check_val("t1_rd_data", dma_data_o[((k < B) ? 0 : 1)*F +: F], 64'h1000 + 64'(k));
      check_val("t1_rd_ready", mem_dma_data_ready_and_o, 1'b1);
      tick();
    end
    #3;
    check_val("t1_empty_ready", mem_dma_data_ready_and_o, 1'b0);
    check_val("t1_empty_v", dma_data_v_o, 2'b00);
    tick();
    mem_dma_data_v_i = 1'b0;

    // port1 write of 8 beats
    dma_pkt_i[1*W +: W] = mk_pkt(1'b1, 32'h0000_0100);
    dma_pkt_v_i = 2'b10; mem_dma_pkt_yumi_i = 1'b1;
    dma_data_i[1*F +: F] = 64'hA0; dma_data_v_i = 2'b10;
    #3;
    check_val("t2_yumi", dma_pkt_yumi_o, 2'b10);
    check_val("t2_pkt", mem_dma_pkt_o, mk_pkt(1'b1, 32'h0000_0100));
    check_val("t2_no_same_cycle_data", mem_dma_data_v_o, 1'b0);
    tick();
    dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
    for (int k = 0; k < B; k++) begin
      dma_data_i[1*F +: F] = 64'hA0 + 64'(k); dma_data_v_i = 2'b10; mem_dma_data_yumi_i = 1'b1;
      #3;
      check_val("t2_wr_data", mem_dma_data_o, 64'hA0 + 64'(k));
      check_val("t2_wr_v", mem_dma_data_v_o, 1'b1);
      check_val("t2_wr_yumi", dma_data_yumi_o, 2'b10);
      tick();
    end
    mem_dma_data_yumi_i = 1'b0;
    #3;
    check_val("t2_wr_empty", mem_dma_data_v_o, 1'b0);
    tick();
    dma_data_v_i = '0;

    // fill the read FIFO, 5th read blocked while a write still gets through
    dma_pkt_v_i = 2'b01; mem_dma_pkt_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dma_pkt_i[0*W +: W] = mk_pkt(1'b0, 32'h8000_1000 + 32'(k*64));
      #3;
      check_val("t3_rd_yumi", dma_pkt_yumi_o, 2'b01);
      tick();
    end
    dma_pkt_i[0*W +: W] = mk_pkt(1'b0, 32'h8000_1100);
    dma_pkt_i[1*W +: W] = mk_pkt(1'b1, 32'h0000_0200);
    dma_pkt_v_i = 2'b11;
    #3;
    check_val("t3_full_wr_yumi", dma_pkt_yumi_o, 2'b10);
    check_val("t3_full_wr_pkt", mem_dma_pkt_o, mk_pkt(1'b1, 32'h0000_0200));
    tick();
    dma_pkt_v_i = 2'b01;
    #3;
    check_val("t3_full_pkt_v", mem_dma_pkt_v_o, 1'b0);
    check_val("t3_full_yumi", dma_pkt_yumi_o, 2'b00);
    tick();
    dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
    for (int k = 0; k < B; k++) begin
      dma_data_i[1*F +: F] = 64'hB0 + 64'(k); dma_data_v_i = 2'b10; mem_dma_data_yumi_i = 1'b1;
      #3;
      check_val("t3_wr_data", mem_dma_data_o, 64'hB0 + 64'(k));
      tick();
    end
    dma_data_v_i = '0; mem_dma_data_yumi_i = 1'b0;

    // drain 4 port0 bursts with a ready stall on beat 3
    acc = 0;
    for (int c = 0; c < 4*B + 1; c++) begin
      stall = (c == 3);
      mem_dma_data_v_i = 1'b1; mem_dma_data_i = 64'h3000 + 64'(acc);
      dma_data_ready_and_i = stall ? 2'b10 : 2'b11;
      #3;
      check_val("t4_ready", mem_dma_data_ready_and_o, !stall);
      check_val("t4_v", dma_data_v_o, 2'b01);
      check_val("t4_data", dma_data_o[0 +: F], 64'h3000 + 64'(acc));
      if (!stall) acc++;
      tick();
    end
    dma_data_ready_and_i = 2'b11;
    #3;
    check_val("t4_drained", mem_dma_data_ready_and_o, 1'b0);
    tick();
    mem_dma_data_v_i = 1'b0;

    // both ports always requesting: grants alternate across 20 packets
    for (int g = 0; g < 5; g++) begin
      dma_pkt_v_i = 2'b11; mem_dma_pkt_yumi_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
        dma_pkt_i[0*W +: W] = mk_pkt(1'b0, 32'h9000_0000 + 32'((g*4+k)*64));
        dma_pkt_i[1*W +: W] = mk_pkt(1'b0, 32'h9100_0000 + 32'((g*4+k)*64));
        #3;
        check_val("t5_alt", dma_pkt_yumi_o, (((g*4+k) % 2) == 0) ? 2'b01 : 2'b10);
        tick();
      end
      dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
      for (int b = 0; b < 4*B; b++) begin
        mem_dma_data_v_i = 1'b1; mem_dma_data_i = 64'(b);
        #3;
        check_val("t5_drain_v", dma_data_v_o, (((b / B) % 2) == 0) ? 2'b01 : 2'b10);
        tick();
      end
      mem_dma_data_v_i = 1'b0;
    end

    // reset during read beat 2
    dma_pkt_i[0*W +: W] = mk_pkt(1'b0, 32'h8000_2000);
    dma_pkt_v_i = 2'b01; mem_dma_pkt_yumi_i = 1'b1;
    #3;
    check_val("t6_yumi", dma_pkt_yumi_o, 2'b01);
    tick();
    dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_dma_data_v_i = 1'b1; mem_dma_data_i = 64'h5000 + 64'(k);
      tick();
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    mem_dma_data_v_i = 1'b1; dma_data_v_i = 2'b11; mem_dma_data_yumi_i = 1'b1;
    #3;
    check_val("t6_ready", mem_dma_data_ready_and_o, 1'b0);
    check_val("t6_data_v", dma_data_v_o, 2'b00);
    check_val("t6_mem_wv", mem_dma_data_v_o, 1'b0);
    check_val("t6_data_yumi", dma_data_yumi_o, 2'b00);
    check_val("t6_pkt_v", mem_dma_pkt_v_o, 1'b0);
    check_val("t6_pkt_yumi", dma_pkt_yumi_o, 2'b00);
    tick();
    mem_dma_data_v_i = 1'b0; dma_data_v_i = '0; mem_dma_data_yumi_i = 1'b0;
    p = mk_pkt(1'b0, 32'h8000_3000);
    dma_pkt_i[0*W +: W] = p;
    dma_pkt_i[1*W +: W] = mk_pkt(1'b0, 32'h8000_3040);
    dma_pkt_v_i = 2'b11; mem_dma_pkt_yumi_i = 1'b1;
    #3;
    check_val("t6_ptr_reset", dma_pkt_yumi_o, 2'b01);
    check_val("t6_ptr_pkt", mem_dma_pkt_o, p);
    tick();
    dma_pkt_v_i = '0; mem_dma_pkt_yumi_i = 1'b0;
    for (int k = 0; k < B; k++) begin
      mem_dma_data_v_i = 1'b1; mem_dma_data_i = 64'h6000 + 64'(k);
      #3;
      check_val("t6_post_v", dma_data_v_o, 2'b01);
      tick();
    end
    #3;
    check_val("t6_post_drained", mem_dma_data_ready_and_o, 1'b0);
    tick();
    mem_dma_data_v_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
